// File: rtl/nibble_serial_adder.sv
// Serial adder: W = 4*NIBBLES-bit operands added one nibble per clock through a 4-bit slice.
// Optional signed-overflow output enabled by defining NIBBLE_SERIAL_ADDER_OVF_EN.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   c_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   c_out,
  output logic                   busy
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  ,
  output logic                   ovf
`endif
);

  localparam int W = 4 * NIBBLES;
  localparam logic [4:0] LAST_IDX = 5'(NIBBLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   a_sh, b_sh, res_reg, res_nxt;
  logic           carry_reg;
  logic [4:0]     idx;
  logic [4:0]     slice;
  logic           accept, is_last;

  assign slice   = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0, carry_reg};
  // New nibble enters at the top; after NIBBLES shifts nibble 0 sits at the bottom.
  assign res_nxt = (res_reg >> 4) | (W'(slice[3:0]) << (W - 4));
  assign is_last = (idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (is_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh      <= '0;
      b_sh      <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      c_out     <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf       <= 1'b0;
`endif
    end else if (accept) begin
      a_sh      <= a;
      b_sh      <= b;
      carry_reg <= c_in;
      idx       <= '0;
    end else if (state == S_RUN) begin
      a_sh      <= a_sh >> 4;
      b_sh      <= b_sh >> 4;
      carry_reg <= slice[4];
      idx       <= idx + 5'd1;
      res_reg   <= res_nxt;
      if (is_last) begin
        sum   <= res_nxt;
        c_out <= slice[4];
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        // Carry into the MSB is recovered from the MSB's own sum bit.
        ovf   <= (a_sh[3] ^ b_sh[3] ^ slice[3]) ^ slice[4];
`endif
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed scoreboard bench for nibble_serial_adder (NIBBLES=4 and NIBBLES=1 instances).
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0, c_in = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        in_ready, out_valid, c_out, busy;
  logic [15:0] sum;
  logic        in_valid1 = 1'b0, out_ready1 = 1'b0, c_in1 = 1'b0;
  logic [3:0]  a1 = '0, b1 = '0;
  logic        in_ready1, out_valid1, c_out1, busy1;
  logic [3:0]  sum1;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic        ovf, ovf1;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] s;
    logic        cy;
    logic        ov;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .busy(busy)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .c_in(c_in1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .c_out(c_out1), .busy(busy1)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push16(input logic [15:0] ta, input logic [15:0] tb_, input logic tc);
    logic [16:0] full;
    exp_t e;
    full = {1'b0, ta} + {1'b0, tb_} + {16'b0, tc};
    e.s  = full[15:0];
    e.cy = full[16];
    e.ov = (ta[15] == tb_[15]) && (full[15] != ta[15]);
    q.push_back(e);
  endtask

  // One operation on the 16-bit instance; operands are scrambled during RUN.
  task automatic op4(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input int bp);
    exp_t e;
    int   cyc;
    push16(ta, tb_, tc);
    in_valid = 1'b1; a = ta; b = tb_; c_in = tc;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'hAAAA; b = 16'h5555; c_in = ~tc;
    chk("in_ready_after_accept", {31'b0, in_ready}, 32'd0);
    chk("busy_after_accept", {31'b0, busy}, 32'd1);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency4", cyc, 32'd4);
    e = q.pop_front();
    chk("sum4", {16'b0, sum}, {16'b0, e.s});
    chk("c_out4", {31'b0, c_out}, {31'b0, e.cy});
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    chk("ovf4", {31'b0, ovf}, {31'b0, e.ov});
`endif
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_sum", {16'b0, sum}, {16'b0, e.s});
      chk("bp_c_out", {31'b0, c_out}, {31'b0, e.cy});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_hs", {31'b0, out_valid}, 32'd0);
    chk("in_ready_after_hs", {31'b0, in_ready}, 32'd1);
    chk("sum_held_idle", {16'b0, sum}, {16'b0, e.s});
  endtask

  initial begin
    exp_t e;
    int   cyc;
    int   seen;
    #12;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_sum", {16'b0, sum}, 32'd0);
    chk("rst_c_out", {31'b0, c_out}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    op4(16'hFFFF, 16'h0001, 1'b0, 0);
    op4(16'h1234, 16'h4321, 1'b1, 5);
    chk("directed_5556", {16'b0, sum}, 32'h5556);

    // Abort in the second RUN cycle.
    in_valid = 1'b1; a = 16'hF0F0; b = 16'h0F0F; c_in = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1; #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_sum", {16'b0, sum}, 32'd0);
    #2 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("abort_no_result", seen, 32'd0);
    op4(16'h0002, 16'h0003, 1'b0, 0);
    chk("directed_0005", {16'b0, sum}, 32'h0005);

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    op4(16'h7FFF, 16'h0001, 1'b0, 0);
    chk("ovf_7fff", {31'b0, ovf}, 32'd1);
    op4(16'hFFFF, 16'h0001, 1'b0, 0);
    chk("ovf_ffff", {31'b0, ovf}, 32'd0);
`endif
    op4(16'h8000, 16'h8000, 1'b1, 1);
    op4(16'hBEEF, 16'h1357, 1'b0, 0);

    // Single-nibble instance.
    push16(16'h000F, 16'h0001, 1'b1);
    in_valid1 = 1'b1; a1 = 4'hF; b1 = 4'h1; c_in1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0; a1 = 4'h0;
    chk("n1_busy", {31'b0, busy1}, 32'd1);
    cyc = 0;
    while (!out_valid1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("n1_latency", cyc, 32'd1);
    e = q.pop_front();
    chk("n1_sum", {28'b0, sum1}, {28'b0, e.s[3:0]});
    chk("n1_c_out", {31'b0, c_out1}, {31'b0, e.s[4]});
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    chk("n1_in_ready", {31'b0, in_ready1}, 32'd1);
    chk("queue_empty", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-word serial adder that adds two `4*NIBBLES`-bit operands plus a carry-in through a single 4-bit ripple add slice, one nibble per clock, LSB nibble first. The slice carry is registered between cycles. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It gives wide additions at the area cost of one 4-bit adder.

## Interface
- `NIBBLES`, default 4: number of 4-bit slices per operand. Legal range 1..16. Operand width W = 4*NIBBLES.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operands and carry-in are valid.
- `in_ready`  out  1  block can accept operands (high only in IDLE).
- `a`  in  W  operand A.
- `b`  in  W  operand B.
- `c_in`  in  1  carry into nibble 0.
- `out_valid`  out  1  result is valid (high only in DONE).
- `out_ready`  in  1  consumer accepts the result.
- `sum`  out  W  result, A+B+c_in mod 2^W.
- `c_out`  out  1  carry out of the top nibble.
- `busy`  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`: latch `a`, `b` and `c_in` into internal shift registers, set nibble index idx=0, go to RUN.
- **RUN**
  - Each cycle the slice adds a[4*idx+3:4*idx] + b[4*idx+3:4*idx] + carry_reg.
  - The 4-bit result shifts into the result register from the top. After NIBBLES cycles the result is LSB-aligned.
  - The slice carry-out is written to carry_reg, and idx increments.
  - On the cycle processing idx=NIBBLES-1: copy the result register to `sum` and the final carry to `c_out`, then go to DONE.
- **DONE**
  - `out_valid`=1; `sum`/`c_out` are held stable.
  - On `out_valid && out_ready`: go to IDLE.
- Inputs `a`, `b` and `c_in` are ignored outside the accept handshake. Changes during RUN do not affect the result.
- `in_valid` asserted during RUN or DONE is not accepted; the producer must hold it.
- `sum`/`c_out` keep the last completed result through IDLE and RUN. They change only on entry to DONE.
- Arithmetic is unsigned modulo 2^W; `c_out` is the W-th bit of the result.
- NIBBLES=1: RUN lasts exactly one cycle.
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `sum`=0, `c_out`=0. Internal operand, carry and index registers are all 0.
- Reset mid-operation: asserting `rst` in RUN or DONE immediately aborts and discards the operation. Outputs take their reset values asynchronously. No result is emitted.

## Timing
- Accept edge E0 is the first edge where `in_valid && in_ready`.
- `in_ready` drops after E0.
- `out_valid` rises after edge E0+NIBBLES, so latency is NIBBLES cycles from accept to valid result.
- Result handshake on edge E1 gives `out_valid`=0 and `in_ready`=1 after E1.
- No same-cycle accept on E1. The next accept is at earliest E1+1.
- Peak throughput: one addition per NIBBLES+2 cycles.
- `out_valid` has no combinational path from `out_ready`. `in_ready` has no combinational path from `in_valid`. All outputs are registered.

## Configuration
- Macro: `NIBBLE_SERIAL_ADDER_OVF_EN`.
- **Defined:** adds output port `ovf` (out, 1). It carries the two's-complement signed overflow of the W-bit addition:
  - `ovf` = carry into MSB XOR carry out of MSB, captured on entry to DONE.
  - It is held with `sum`, resets to 0 and is cleared on reset.
- **Not defined:** the `ovf` port and its logic are absent. All other behaviour is identical.

## Test plan
- NIBBLES=4, a=0xFFFF, b=0x0001, c_in=0 -> `out_valid` 4 cycles after accept, `sum`=0x0000, `c_out`=1.
- NIBBLES=4, a=0x1234, b=0x4321, c_in=1 -> `sum`=0x5556, `c_out`=0. Changing `a` to 0xAAAA during RUN does not alter the result.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` -> `sum`/`c_out` stable and `out_valid` held. Then `out_ready`=1 for one cycle -> `in_ready`=1 on the next cycle.
- Pulse `rst` during the second RUN cycle of a=0xF0F0, b=0x0F0F -> `busy`=0, `out_valid`=0, `sum`=0 immediately. No `out_valid` follows. The next operation 0x0002+0x0003 yields 0x0005.
- NIBBLES=1, a=0xF, b=0x1, c_in=1 -> `out_valid` 1 cycle after accept, `sum`=0x1, `c_out`=1.
- With `NIBBLE_SERIAL_ADDER_OVF_EN`, NIBBLES=4:
  - 0x7FFF+0x0001 -> `sum`=0x8000, `ovf`=1, `c_out`=0.
  - 0xFFFF+0x0001 -> `ovf`=0, `c_out`=1.
